// File: rtl/count_ext_pkg.sv
// Shared types and constants for the ripple-count extender.
// Holds the snapshot FSM state type, the default widths and the total-width helper.
package count_ext_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 12;

    typedef enum logic {
        IDLE,
        HOLD
    } snap_state_t;

    function automatic int ext_width(input int n, input int w);
        return n + w;
    endfunction

endpackage

// File: rtl/count_extender_if.sv
// Bus between the count extender and its environment.
// Carries the ripple count, control inputs, the extended count, its flags and the snapshot port.
interface count_extender_if
    import count_ext_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
);
    localparam int T = ext_width(N, W);

    logic [N-1:0] count_in;
    logic         clr;
    logic [T-1:0] thresh;
    logic         snap_req;
    logic         rd_ready;
    logic [T-1:0] ext_count;
    logic         match;
    logic         wrap;
    logic         step_err;
    logic         ovf;
    logic         snap_valid;
    logic [T-1:0] snap_data;
    logic         snap_miss;

    modport master (
        output count_in, clr, thresh, snap_req, rd_ready,
        input  ext_count, match, wrap, step_err, ovf, snap_valid, snap_data, snap_miss
    );

    modport slave (
        input  count_in, clr, thresh, snap_req, rd_ready,
        output ext_count, match, wrap, step_err, ovf, snap_valid, snap_data, snap_miss
    );

endinterface

// File: rtl/count_sync_filter.sv
// Double-samples the asynchronously settling ripple count and offers a value
// only after it has held for two consecutive clk samples and differs from lo.
module count_sync_filter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] count_in,
    input  logic [N-1:0] lo,
    output logic         accept,
    output logic [N-1:0] value
);

    logic [N-1:0] s1;
    logic [N-1:0] s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= count_in;
            s2 <= s1;
        end
    end

    // A glitch between the two samples shows up as s1 != s2 and is ignored.
    assign accept = (s1 == s2) && (s2 != lo);
    assign value  = s2;

endmodule

// File: rtl/count_extender.sv
// Extends a filtered N-bit ripple count to N+W bits by counting wraps, flags
// threshold hits and step errors, and serves snapshots over a valid/ready port.
module count_extender
    import count_ext_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) (
    input  logic             clk,
    input  logic             rst,
    count_extender_if.slave  bus
);

    localparam int T = ext_width(N, W);

    logic [N-1:0] lo;
    logic [W-1:0] hi;
    logic [W-1:0] hi_next;
    logic [N-1:0] lo_inc;
    logic [N-1:0] value;
    logic         accept;
    logic         prime;
    logic         is_step;
    logic         is_wrap;
    logic         match_q;
    logic         wrap_q;
    logic         step_err_q;
    logic         ovf_q;
    logic [T-1:0] ext;

    snap_state_t  state_q;
    snap_state_t  state_d;
    logic         capture;
    logic         miss_set;
    logic [T-1:0] snap_data_q;
    logic         snap_miss_q;

    count_sync_filter #(.N(N)) u_filter (
        .clk      (clk),
        .rst      (rst),
        .count_in (bus.count_in),
        .lo       (lo),
        .accept   (accept),
        .value    (value)
    );

    assign ext     = {hi, lo};
    assign lo_inc  = lo + 1'b1;
    assign is_step = (value == lo_inc) && (value != '0);
    assign is_wrap = (value == '0) && (lo == '1);

    always_comb begin
        hi_next = hi;
        if (prime && is_wrap) begin
            hi_next = hi + 1'b1;
        end
    end

    // The first accept after reset or clr only primes lo; clr wins over a same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo         <= '0;
            hi         <= '0;
            prime      <= 1'b0;
            match_q    <= 1'b0;
            wrap_q     <= 1'b0;
            step_err_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            match_q <= 1'b0;
            wrap_q  <= 1'b0;
            if (bus.clr) begin
                hi         <= '0;
                prime      <= 1'b0;
                step_err_q <= 1'b0;
                ovf_q      <= 1'b0;
            end else if (accept) begin
                lo      <= value;
                hi      <= hi_next;
                prime   <= 1'b1;
                match_q <= ({hi_next, value} == bus.thresh);
                if (prime) begin
                    if (is_wrap) begin
                        wrap_q <= 1'b1;
                        if (hi == '1) begin
                            ovf_q <= 1'b1;
                        end
                    end else if (!is_step) begin
                        step_err_q <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests arriving while a snapshot is held are dropped, even alongside rd_ready.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        miss_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.snap_req) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.snap_req) begin
                    miss_set = 1'b1;
                end
                if (bus.rd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_data_q <= '0;
            snap_miss_q <= 1'b0;
        end else begin
            if (capture) begin
                snap_data_q <= ext;
            end
            if (bus.clr) begin
                snap_miss_q <= 1'b0;
            end else if (miss_set) begin
                snap_miss_q <= 1'b1;
            end
        end
    end

    assign bus.ext_count  = ext;
    assign bus.match      = match_q;
    assign bus.wrap       = wrap_q;
    assign bus.step_err   = step_err_q;
    assign bus.ovf        = ovf_q;
    assign bus.snap_valid = (state_q == HOLD);
    assign bus.snap_data  = snap_data_q;
    assign bus.snap_miss  = snap_miss_q;

endmodule

// File: tb/tb_count_extender.sv
// Directed bench for count_extender: a vector table for the count/wrap/match path
// plus hand-written sequences for glitch filtering, snapshots, overflow and reset.
module tb_count_extender;
    import count_ext_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    count_extender_if #(.N(4), .W(12)) bus ();
    count_extender_if #(.N(4), .W(2))  bus2 ();

    count_extender #(.N(4), .W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    count_extender #(.N(4), .W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [3:0]  cnt;
        logic        clr;
        logic [15:0] exp_ext;
        logic [3:0]  exp_wrap_mask;
        logic [3:0]  exp_match_mask;
        logic        exp_step;
    } vec_t;

    vec_t vecs [13];
    int   checks = 0;
    int   fails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Each vector holds its input for four cycles; bit i of a mask is the pulse seen at the (i+1)th negedge.
    task automatic applyStimulus(input vec_t v, output logic [3:0] wmask, output logic [3:0] mmask);
        bus.count_in = v.cnt;
        bus.clr      = v.clr;
        wmask        = '0;
        mmask        = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wmask[i] = bus.wrap;
            mmask[i] = bus.match;
            bus.clr  = 1'b0;
        end
    endtask

    task automatic runVector(input int idx);
        logic [3:0] wm;
        logic [3:0] mm;
        applyStimulus(vecs[idx], wm, mm);
        checkOutput($sformatf("vec%0d ext_count", idx), 32'(bus.ext_count), 32'(vecs[idx].exp_ext));
        checkOutput($sformatf("vec%0d wrap timing", idx), 32'(wm), 32'(vecs[idx].exp_wrap_mask));
        checkOutput($sformatf("vec%0d match timing", idx), 32'(mm), 32'(vecs[idx].exp_match_mask));
        checkOutput($sformatf("vec%0d step_err", idx), 32'(bus.step_err), 32'(vecs[idx].exp_step));
        checkOutput($sformatf("vec%0d ovf", idx), 32'(bus.ovf), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic seen7;
        int   wraps2;

        vecs[0]  = '{4'd1,  1'b0, 16'h001, 4'b0000, 4'b0000, 1'b0};
        vecs[1]  = '{4'd2,  1'b0, 16'h002, 4'b0000, 4'b0000, 1'b0};
        vecs[2]  = '{4'd2,  1'b1, 16'h002, 4'b0000, 4'b0000, 1'b0};
        vecs[3]  = '{4'd14, 1'b0, 16'h00E, 4'b0000, 4'b0000, 1'b0};
        vecs[4]  = '{4'd15, 1'b0, 16'h00F, 4'b0000, 4'b0000, 1'b0};
        vecs[5]  = '{4'd0,  1'b0, 16'h010, 4'b0100, 4'b0000, 1'b0};
        vecs[6]  = '{4'd1,  1'b0, 16'h011, 4'b0000, 4'b0000, 1'b0};
        vecs[7]  = '{4'd2,  1'b0, 16'h012, 4'b0000, 4'b0100, 1'b0};
        vecs[8]  = '{4'd3,  1'b0, 16'h013, 4'b0000, 4'b0000, 1'b0};
        vecs[9]  = '{4'd9,  1'b0, 16'h019, 4'b0000, 4'b0000, 1'b1};
        vecs[10] = '{4'd10, 1'b0, 16'h01A, 4'b0000, 4'b0000, 1'b1};
        vecs[11] = '{4'd10, 1'b1, 16'h00A, 4'b0000, 4'b0000, 1'b0};
        vecs[12] = '{4'd11, 1'b0, 16'h00B, 4'b0000, 4'b0000, 1'b0};

        rst           = 1'b1;
        bus.count_in  = '0;
        bus.clr       = 1'b0;
        bus.thresh    = 16'h012;
        bus.snap_req  = 1'b0;
        bus.rd_ready  = 1'b0;
        bus2.count_in = '0;
        bus2.clr      = 1'b0;
        bus2.thresh   = '0;
        bus2.snap_req = 1'b0;
        bus2.rd_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset ext_count", 32'(bus.ext_count), 32'd0);
        checkOutput("reset flags", {27'd0, bus.match, bus.wrap, bus.step_err, bus.ovf, bus.snap_miss}, 32'd0);
        checkOutput("reset snap_valid", 32'(bus.snap_valid), 32'd0);
        checkOutput("reset snap_data", 32'(bus.snap_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] count, wrap and match vectors");
        for (int i = 0; i < 9; i++) begin
            runVector(i);
        end

        // A one-cycle 7 between 3 and 4 must never reach lo.
        $display("[TB] glitch filtering");
        seen7        = 1'b0;
        bus.count_in = 4'd7;
        @(negedge clk);
        if (bus.ext_count == 16'h017) seen7 = 1'b1;
        bus.count_in = 4'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.ext_count == 16'h017) seen7 = 1'b1;
        end
        checkOutput("glitch never accepted", 32'(seen7), 32'd0);
        checkOutput("glitch ext_count", 32'(bus.ext_count), 32'h014);
        checkOutput("glitch step_err", 32'(bus.step_err), 32'd0);

        for (int i = 9; i < 13; i++) begin
            runVector(i);
        end

        $display("[TB] snapshot hold and miss");
        bus.snap_req = 1'b1;
        @(negedge clk);
        bus.snap_req = 1'b0;
        checkOutput("snap_valid rise", 32'(bus.snap_valid), 32'd1);
        checkOutput("snap_data capture", 32'(bus.snap_data), 32'h00B);
        bus.count_in = 4'd12;
        repeat (2) @(negedge clk);
        bus.snap_req = 1'b1;
        @(negedge clk);
        bus.snap_req = 1'b0;
        @(negedge clk);
        checkOutput("snap_data frozen", 32'(bus.snap_data), 32'h00B);
        checkOutput("snap_miss set", 32'(bus.snap_miss), 32'd1);
        checkOutput("snap_valid held", 32'(bus.snap_valid), 32'd1);
        checkOutput("ext_count during hold", 32'(bus.ext_count), 32'h00C);
        bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.rd_ready = 1'b0;
        checkOutput("snap_valid fall", 32'(bus.snap_valid), 32'd0);

        // Request lands on the same edge that updates lo: the older value is captured.
        bus.count_in = 4'd13;
        repeat (2) @(negedge clk);
        bus.snap_req = 1'b1;
        @(negedge clk);
        bus.snap_req = 1'b0;
        checkOutput("same-cycle snap_data", 32'(bus.snap_data), 32'h00C);
        checkOutput("same-cycle ext_count", 32'(bus.ext_count), 32'h00D);

        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        checkOutput("clr snap_miss", 32'(bus.snap_miss), 32'd0);
        checkOutput("clr keeps hold", 32'(bus.snap_valid), 32'd1);
        bus.snap_req = 1'b1;
        bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.snap_req = 1'b0;
        bus.rd_ready = 1'b0;
        checkOutput("req with ready dropped", 32'(bus.snap_valid), 32'd0);
        checkOutput("req with ready miss", 32'(bus.snap_miss), 32'd1);
        bus.snap_req = 1'b1;
        @(negedge clk);
        bus.snap_req = 1'b0;
        checkOutput("recapture valid", 32'(bus.snap_valid), 32'd1);
        checkOutput("recapture data", 32'(bus.snap_data), 32'h00D);

        $display("[TB] hi overflow with W=2");
        wraps2 = 0;
        for (int w = 0; w < 16; w++) begin
            for (int c = 1; c <= 16; c++) begin
                bus2.count_in = 4'(c);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (bus2.wrap) wraps2++;
                end
            end
            if (w == 2) begin
                checkOutput("w2 three wraps ext", 32'(bus2.ext_count), 32'h30);
                checkOutput("w2 three wraps ovf", 32'(bus2.ovf), 32'd0);
            end
            if (w == 3) begin
                checkOutput("w2 four wraps ext", 32'(bus2.ext_count), 32'h00);
                checkOutput("w2 four wraps ovf", 32'(bus2.ovf), 32'd1);
            end
        end
        checkOutput("w2 wrap pulses", 32'(wraps2), 32'd16);
        checkOutput("w2 final ext", 32'(bus2.ext_count), 32'h00);
        checkOutput("w2 final ovf", 32'(bus2.ovf), 32'd1);
        checkOutput("w2 step_err", 32'(bus2.step_err), 32'd0);

        $display("[TB] reset during hold");
        checkOutput("pre-reset hold", 32'(bus.snap_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async snap_valid", 32'(bus.snap_valid), 32'd0);
        checkOutput("async snap_data", 32'(bus.snap_data), 32'd0);
        checkOutput("async ext_count", 32'(bus.ext_count), 32'd0);
        checkOutput("async flags", {27'd0, bus.match, bus.wrap, bus.step_err, bus.ovf, bus.snap_miss}, 32'd0);
        checkOutput("async w2 ovf", 32'(bus2.ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
